// File: rtl/dither_seq.sv
// Purpose: two-stage pixel sequencer that walks one frame of RGB888 pixels, hands each
//          pixel and its coordinates to an external dithering datapath and emits RGB444.
// Latency: 2 cycles from input acceptance to out_valid; 1 pixel/cycle throughput.
// Backpressure: out_ready low freezes both stages and drops in_ready in the same cycle.
// Optional: define DITHER_SEQ_BYPASS_EN to add a 'bypass' input that loads the
//           truncated stage-1 pixel into stage 2 instead of the dithering result.
module dither_seq #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
`ifdef DITHER_SEQ_BYPASS_EN
  input  logic        bypass,
`endif
  input  logic [23:0] in_pixel,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] pixel_in,
  output logic [10:0] hc_visible,
  output logic [10:0] vc_visible,
  input  logic [11:0] dithering,
  output logic [11:0] out_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eol,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [10:0] col;
  logic [10:0] row;
  logic        s1_valid;
  logic        s1_sof;
  logic        s1_eol;
  logic        adv;
  logic        accept;
  logic        last_pix;
  logic        frame_start;
  logic [11:0] s2_dat;

  // Both stages move together whenever the output register is free or being drained.
  assign adv         = !out_valid || out_ready;
  assign in_ready    = (state == RUN) && adv && !abort;
  assign accept      = in_valid && in_ready;
  assign last_pix    = (col == H_LAST) && (row == V_LAST);
  assign frame_start = (state == IDLE) && start && !abort;

`ifdef DITHER_SEQ_BYPASS_EN
  assign s2_dat = bypass ? {pixel_in[23:20], pixel_in[15:12], pixel_in[7:4]} : dithering;
`else
  assign s2_dat = dithering;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs; abort overrides every transition and hides frame_done.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (accept && last_pix) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!s1_valid && !out_valid) begin
          state_nxt  = IDLE;
          frame_done = !abort;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = IDLE;
    end
  end

  // Raster counters: column wraps at end of line and bumps the line counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (abort || frame_start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == H_LAST) begin
        col <= '0;
        row <= row + 11'd1;
      end else begin
        col <= col + 11'd1;
      end
    end
  end

  // Stage 1: capture the accepted pixel with its coordinates and frame markers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sof     <= 1'b0;
      s1_eol     <= 1'b0;
      pixel_in   <= '0;
      hc_visible <= '0;
      vc_visible <= '0;
    end else if (abort) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= accept;
      if (accept) begin
        pixel_in   <= in_pixel;
        hc_visible <= col;
        vc_visible <= row;
        s1_sof     <= (col == '0) && (row == '0);
        s1_eol     <= (col == H_LAST);
      end
    end
  end

  // Stage 2: register the datapath result; contents are frozen while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (abort) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_pixel <= s2_dat;
        out_sof   <= s1_sof;
        out_eol   <= s1_eol;
      end
    end
  end

endmodule

// File: tb/tb_dither_seq.sv
// Bench for dither_seq: cycle table for a 4x3 frame, hand sequences for stall, abort,
// mid-frame reset and line wrap, plus randomized frames against a queue-based model.
module tb_dither_seq;

  localparam int H    = 4;
  localparam int V    = 3;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        bypass = 1'b0;
  logic [23:0] in_pixel = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_sof, out_eol, busy, frame_done;
  logic [23:0] pixel_in;
  logic [10:0] hc_visible, vc_visible;
  logic [11:0] dithering, out_pixel;

  logic        w_start = 1'b0;
  logic        w_in_valid = 1'b0;
  logic        w_out_ready = 1'b0;
  logic        w_in_ready, w_out_valid, w_sof, w_eol, w_busy, w_done;
  logic [23:0] w_pixel_in;
  logic [10:0] w_hc, w_vc;
  logic [11:0] w_out_pixel;

  always #5 clk = ~clk;

  // Stand-in dithering datapath: nibble truncation mixed with the coordinates.
  function automatic logic [11:0] dith_f(input logic [23:0] p, input logic [10:0] h, input logic [10:0] v);
    return {p[23:20] ^ h[3:0], p[15:12] ^ v[3:0], p[7:4] ^ h[3:0] ^ v[3:0]};
  endfunction

  assign dithering = dith_f(pixel_in, hc_visible, vc_visible);

  dither_seq #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
`ifdef DITHER_SEQ_BYPASS_EN
    .bypass(bypass),
`endif
    .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .pixel_in(pixel_in), .hc_visible(hc_visible), .vc_visible(vc_visible),
    .dithering(dithering), .out_pixel(out_pixel), .out_valid(out_valid),
    .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol),
    .busy(busy), .frame_done(frame_done)
  );

  // Second instance with full-width 1024-pixel lines for the coordinate wrap.
  dither_seq #(.H_ACTIVE(1024), .V_ACTIVE(2)) dut_wide (
    .clk(clk), .rst(rst), .start(w_start), .abort(1'b0),
`ifdef DITHER_SEQ_BYPASS_EN
    .bypass(1'b0),
`endif
    .in_pixel(24'h000000), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .pixel_in(w_pixel_in), .hc_visible(w_hc), .vc_visible(w_vc),
    .dithering(12'h000), .out_pixel(w_out_pixel), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_sof(w_sof), .out_eol(w_eol),
    .busy(w_busy), .frame_done(w_done)
  );

  typedef struct packed {
    logic [11:0] pix;
    logic        sof;
    logic        eol;
  } exp_t;

  typedef struct packed {
    logic st, iv, ordy, ir, ov, sof, eol, busy, done;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        e;
  vec_t        tbl[17];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          k = 0;
  int          n_out = 0;
  int          n_acc = 0;
  int          done_cnt = 0;
  int          col, row, o0, d0, a0, cyc, wcnt, wtag;
  bit          wdone;
  logic        pend = 1'b0;
  logic [10:0] pend_h, pend_v;
  logic        stall = 1'b0;
  logic [13:0] held;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_pixel"}, out_pixel, 0);
    chk({tag, "_out_sof"}, out_sof, 0);
    chk({tag, "_out_eol"}, out_eol, 0);
    chk({tag, "_pixel_in"}, pixel_in, 0);
    chk({tag, "_hc"}, hc_visible, 0);
    chk({tag, "_vc"}, vc_visible, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic run_to_done(input string tag, input int exp_outs, input int out0, input int done0, input bit rnd);
    int c = 0;
    while (done_cnt == done0 && c < 400) begin
      if (rnd) in_pixel = 24'($urandom);
      @(posedge clk); #1;
      c++;
    end
    chk({tag, "_done"}, done_cnt - done0, 1);
    chk({tag, "_outs"}, n_out - out0, exp_outs);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  // Scoreboard: model frame position from the acceptance count and compare every output.
  always @(negedge clk) begin
    if (!rst) begin
      if (pend) begin
        chk("s1_hc", hc_visible, pend_h);
        chk("s1_vc", vc_visible, pend_v);
        pend = 1'b0;
      end
      if (stall && out_valid) chk("stall_hold", {out_pixel, out_sof, out_eol}, held);
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %0h expected none", out_pixel);
        end else begin
          e = exp_q.pop_front();
          chk("out_pixel", out_pixel, e.pix);
          chk("out_sof", out_sof, e.sof);
          chk("out_eol", out_eol, e.eol);
        end
      end
      if (in_valid && in_ready) begin
        col   = k % H;
        row   = k / H;
        e.pix = bypass ? {in_pixel[23:20], in_pixel[15:12], in_pixel[7:4]}
                       : dith_f(in_pixel, 11'(col), 11'(row));
        e.sof = (k == 0);
        e.eol = (col == H - 1);
        exp_q.push_back(e);
        pend   = 1'b1;
        pend_h = 11'(col);
        pend_v = 11'(row);
        n_acc++;
        k = (k + 1) % NPIX;
      end
      if (frame_done) done_cnt++;
      stall = out_valid && !out_ready;
      held  = {out_pixel, out_sof, out_eol};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // st iv ordy | ir ov sof eol busy done
    tbl[0]  = 9'b111_000000;
    tbl[1]  = 9'b011_100010;
    tbl[2]  = 9'b011_100010;
    tbl[3]  = 9'b011_111010;
    tbl[4]  = 9'b011_110010;
    tbl[5]  = 9'b011_110010;
    tbl[6]  = 9'b011_110110;
    tbl[7]  = 9'b011_110010;
    tbl[8]  = 9'b011_110010;
    tbl[9]  = 9'b011_110010;
    tbl[10] = 9'b011_110110;
    tbl[11] = 9'b011_110010;
    tbl[12] = 9'b011_110010;
    tbl[13] = 9'b011_010010;
    tbl[14] = 9'b011_010110;
    tbl[15] = 9'b011_000011;
    tbl[16] = 9'b011_000000;

    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Full frame, cycle by cycle.
    for (int i = 0; i < 17; i++) begin
      start     = tbl[i].st;
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      in_pixel  = 24'($urandom);
      @(negedge clk);
      chk($sformatf("t%0d_in_ready", i), in_ready, tbl[i].ir);
      chk($sformatf("t%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("t%0d_sof", i), out_valid & out_sof, tbl[i].sof);
      chk($sformatf("t%0d_eol", i), out_valid & out_eol, tbl[i].eol);
      chk($sformatf("t%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("t%0d_frame_done", i), frame_done, tbl[i].done);
      @(posedge clk); #1;
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("table_frames", done_cnt, 1);
    chk("table_outs", n_out, NPIX);

    // Five-cycle output stall in the middle of a frame.
    o0 = n_out; d0 = done_cnt;
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) begin
      in_pixel = 24'($urandom);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      in_pixel = 24'($urandom);
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    run_to_done("bp", NPIX, o0, d0, 1'b1);

    // Randomized frames with stray start pulses while busy.
    for (int f = 0; f < 3; f++) begin
      o0 = n_out; d0 = done_cnt; cyc = 0;
      while (done_cnt == d0 && cyc < 2000) begin
        start     = (cyc == 0) || ($urandom_range(0, 7) == 0);
        in_valid  = ($urandom_range(0, 1) == 1);
        out_ready = ($urandom_range(0, 3) != 0);
        in_pixel  = 24'($urandom);
        @(posedge clk); #1;
        cyc++;
      end
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("rand_done", done_cnt - d0, 1);
      chk("rand_outs", n_out - o0, NPIX);
      chk("rand_queue_left", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
    end

    // Abort after five acceptances, then a clean restart.
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    a0 = n_acc; cyc = 0;
    while (n_acc - a0 < 5 && cyc < 50) begin
      in_pixel = 24'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_accepts", n_acc - a0, 5);
    d0 = done_cnt;
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    exp_q.delete(); k = 0; pend = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("abort_no_done", done_cnt - d0, 0);
    o0 = n_out;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    run_to_done("abort_restart", NPIX, o0, d0, 1'b1);

    // Asynchronous reset in the middle of a frame.
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("rst_mid");
    exp_q.delete(); k = 0; pend = 1'b0; stall = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    o0 = n_out; d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    run_to_done("post_rst", NPIX, o0, d0, 1'b1);

`ifdef DITHER_SEQ_BYPASS_EN
    bypass = 1'b1; in_pixel = 24'hA5C3F0;
    o0 = n_out; d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    run_to_done("bypass", NPIX, o0, d0, 1'b0);
    chk("bypass_pix", out_pixel, 12'hACF);
    bypass = 1'b0;
`endif
    in_valid = 1'b0;

    // 1024-pixel lines: wrap on pixel 1025 and DRAIN after the last pixel.
    wcnt = 0; wtag = 0; wdone = 1'b0;
    w_in_valid = 1'b1; w_out_ready = 1'b1; w_start = 1'b1;
    @(posedge clk); #1 w_start = 1'b0;
    for (int c = 0; c < 2300 && !wdone; c++) begin
      @(negedge clk);
      if (wtag == 1025) begin
        chk("wrap_hc", w_hc, 0);
        chk("wrap_vc", w_vc, 1);
      end else if (wtag == 2048) begin
        chk("last_hc", w_hc, 1023);
        chk("last_vc", w_vc, 1);
        chk("last_busy", w_busy, 1);
        chk("last_in_ready", w_in_ready, 0);
        wdone = 1'b1;
      end
      wtag = 0;
      if (w_in_valid && w_in_ready) begin
        wcnt++;
        wtag = wcnt;
      end
    end
    if (!wdone) chk("wide_accepts", wcnt, 2048);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
